// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   OP_*          : op field encodings seen on the request bus
//   state_t       : FSM state encoding of the iterative datapath
//   OP_USES_HILO  : per-op mask, bit set when the op writes HI and/or LO;
//                   the hazard unit uses it to decide whether an EX op
//                   needs the HI/LO interlock
package mdu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_MULTU = 3'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 3'd1;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 3'd3;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_ADJ  = 2'd2
  } state_t;

  // Ops 0-5 write HI/LO; 6-7 are reserved and ignored.
  localparam logic [7:0] OP_USES_HILO = 8'b0011_1111;

  function automatic logic op_uses_hilo(input logic [OP_W-1:0] op);
    return OP_USES_HILO[op];
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
//   master (pipeline) drives : start, op, a, b, flush
//   slave  (unit)     drives : busy, done, hi, lo, div_zero
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             start;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo, div_zero
  );

endinterface

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate. With neg=1 it returns -din, which
// doubles as |din| when neg is the sign bit of din.
//   din  : operand
//   neg  : 1 to negate
//   dout : din or -din
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? -din : din;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Iterative ops (MULTU/MULT/DIVU/DIV) take WIDTH CALC cycles plus one ADJ
// cycle for the sign fix-up; MTHI/MTLO complete in one cycle.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : mdu_if.slave -- start/op/a/b/flush in, busy/done/hi/lo/div_zero out
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Iteration datapath: upper half = partial product / partial remainder,
  // lower half = multiplier / dividend being consumed (quotient shifts in).
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_raw;     // raw dividend, returned in HI on b==0
  logic               is_div;
  logic               neg_res;   // product / quotient sign
  logic               neg_rem;   // remainder sign (dividend sign)
  logic               b_zero;

  logic               signed_op;
  logic               div_op;
  logic               iter_op;
  logic               accept;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign div_op    = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
  assign iter_op   = (bus.op == OP_MULTU) || (bus.op == OP_MULT) || div_op;
  // flush in the same cycle as start drops the request
  assign accept    = (state == S_IDLE) && bus.start && !bus.flush &&
                     op_uses_hilo(bus.op);

  mdu_negate #(.WIDTH(WIDTH)) u_abs_a (
    .din (bus.a),
    .neg (signed_op & bus.a[WIDTH-1]),
    .dout(a_mag)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_abs_b (
    .din (bus.b),
    .neg (signed_op & bus.b[WIDTH-1]),
    .dout(b_mag)
  );

  // One radix-2 step of either shift-add multiply or restoring divide.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_next;

  assign mul_sum   = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd})
                            : {1'b0, acc[2*WIDTH-1:WIDTH]};
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ge    = (div_shift >= {1'b0, opnd});

  always_comb begin
    acc_next = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_ge) acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up applied in ADJ.
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  mdu_negate #(.WIDTH(WIDTH)) u_fix_q (
    .din (acc[WIDTH-1:0]),
    .neg (neg_res),
    .dout(quot_fix)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_fix_r (
    .din (acc[2*WIDTH-1:WIDTH]),
    .neg (neg_rem),
    .dout(rem_fix)
  );

  mdu_negate #(.WIDTH(2*WIDTH)) u_fix_p (
    .din (acc),
    .neg (neg_res),
    .dout(prod_fix)
  );

  // Control FSM and architectural HI/LO state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            dz_q <= 1'b0;
            if (bus.op == OP_MTHI) begin
              hi_q   <= bus.a;
              done_q <= 1'b1;
            end else if (bus.op == OP_MTLO) begin
              lo_q   <= bus.a;
              done_q <= 1'b1;
            end else begin
              state  <= S_CALC;
              busy_q <= 1'b1;
              cnt    <= '0;
            end
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= S_ADJ;
          end
        end
        S_ADJ: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          if (!bus.flush) begin
            done_q <= 1'b1;
            if (is_div) begin
              if (b_zero) begin
                lo_q <= '1;
                hi_q <= a_raw;
                dz_q <= 1'b1;
              end else begin
                lo_q <= quot_fix;
                hi_q <= rem_fix;
              end
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Operand capture at the accepting edge, then one step per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept && iter_op) begin
      acc     <= div_op ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      opnd    <= div_op ? b_mag : a_mag;
      a_raw   <= bus.a;
      is_div  <= div_op;
      b_zero  <= (bus.b == '0);
      neg_res <= signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      neg_rem <= signed_op & bus.a[WIDTH-1];
    end else if (state == S_CALC) begin
      acc <= acc_next;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32). Inputs are driven and
// outputs sampled on the falling edge; "cycle k" is the period after the
// k-th rising edge following the cycle in which start was raised.
module tb_muldiv_unit;
  import mdu_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;
  logic         exp_dz;

  task automatic check_val(input string tag, input logic [63:0] act,
                           input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Architectural reference: plain integer arithmetic on the op definitions.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] rh,
                                output logic [W-1:0] rl, output logic rdz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = $signed(a);
    sb  = $signed(b);
    rdz = 1'b0;
    rh  = '0;
    rl  = '0;
    if (op == OP_MULTU) begin
      p  = {32'b0, a} * {32'b0, b};
      rh = p[63:32];
      rl = p[31:0];
    end else if (op == OP_MULT) begin
      p  = sa * sb;
      rh = p[63:32];
      rl = p[31:0];
    end else if (b == '0) begin
      rl  = '1;
      rh  = a;
      rdz = 1'b1;
    end else if (op == OP_DIVU) begin
      rl = a / b;
      rh = a % b;
    end else if (a == MIN && b == '1) begin
      rl = MIN;
      rh = '0;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      rl = q[31:0];
      rh = r[31:0];
    end
  endfunction

  task automatic check_outs(input string tag);
    check_val({tag, "_hi"}, bus.hi, exp_hi);
    check_val({tag, "_lo"}, bus.lo, exp_lo);
    check_val({tag, "_dz"}, bus.div_zero, exp_dz);
  endtask

  // Iterative op. Called at a falling edge; returns at the falling edge of
  // the done cycle with start low. xstart_cyc>0 raises a second start in
  // that cycle; flush_cyc>0 raises flush in that cycle.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int xstart_cyc,
                       input int flush_cyc);
    logic [W-1:0] rh, rl;
    logic         rdz;
    bit           fl;
    model(op, a, b, rh, rl, rdz);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.flush = 1'b0;
    exp_dz    = 1'b0;
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      fl = (flush_cyc > 0) && (c > flush_cyc);
      check_val("busy", bus.busy, (c <= W + 1) && !fl);
      check_val("done", bus.done, (c == W + 2) && !fl);
      if (c == W + 2 && !fl) begin
        exp_hi = rh;
        exp_lo = rl;
        exp_dz = rdz;
      end
      check_outs("res");
      bus.start = (c == xstart_cyc);
      bus.op    = (c == xstart_cyc) ? OP_DIVU : op;
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.flush = (c == flush_cyc);
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [W-1:0] a);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = $urandom;
    bus.flush = 1'b0;
    if (op == OP_MTHI) exp_hi = a;
    else               exp_lo = a;
    exp_dz = 1'b0;
    @(negedge clk);
    check_val("mt_done", bus.done, 1'b1);
    check_val("mt_busy", bus.busy, 1'b0);
    check_outs("mt");
    bus.start = 1'b0;
    @(negedge clk);
    check_val("mt_done_pulse", bus.done, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int           rop;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    exp_hi    = '0;
    exp_lo    = '0;
    exp_dz    = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", bus.busy, 1'b0);
    check_val("rst_done", bus.done, 1'b0);
    check_outs("rst");
    rst = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases, issued back to back.
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    check_val("multu_hi_const", exp_hi, 32'hFFFF_FFFE);
    do_op(OP_MULT, -32'sd3, 32'd5, -1, -1);
    do_op(OP_DIV, -32'sd7, 32'd2, -1, -1);
    do_op(OP_DIV, MIN, 32'hFFFF_FFFF, -1, -1);
    do_op(OP_DIVU, 32'd100, 32'd0, -1, -1);

    // flush in the done cycle has no effect; div_zero holds
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check_val("flush_done_done", bus.done, 1'b0);
    check_outs("flush_done");

    // reserved op: nothing happens
    bus.start = 1'b1;
    bus.op    = 3'd6;
    bus.a     = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    check_val("rsvd_done", bus.done, 1'b0);
    check_val("rsvd_busy", bus.busy, 1'b0);
    check_outs("rsvd");

    do_mt(OP_MTHI, 32'h0000_1234);
    do_op(OP_MULTU, 32'd6, 32'd7, -1, -1);
    do_op(OP_MULTU, 32'd6, 32'd7, 5, -1);
    do_op(OP_DIVU, $urandom, $urandom, -1, 10);
    do_op(OP_MULT, $urandom, $urandom, -1, W + 1);

    // flush together with start in IDLE: request dropped
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = $urandom;
    bus.b     = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check_val("fs_busy", bus.busy, 1'b0);
    check_val("fs_done", bus.done, 1'b0);
    check_outs("fs");

    do_mt(OP_MTLO, 32'hCAFE_0001);

    // reset in the middle of a divide
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.a     = 32'd1000;
    bus.b     = 32'd7;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    exp_hi = '0;
    exp_lo = '0;
    exp_dz = 1'b0;
    check_val("mrst_busy", bus.busy, 1'b0);
    check_val("mrst_done", bus.done, 1'b0);
    check_outs("mrst");
    rst = 1'b1;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      check_val("mrst_quiet", {bus.busy, bus.done}, 2'b00);
    end

    // Randomized ops with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = $urandom_range(0, 5);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = MIN; rb = '1; end
        2: rb = $urandom_range(1, 9);
        3: ra = $urandom_range(0, 50);
        4: rb = '1;
        default: ;
      endcase
      if (rop <= 3) do_op(3'(rop), ra, rb, -1, -1);
      else          do_mt(3'(rop), ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
